// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access control for the M stage plus the MEM/WB register.
// Holds the pipeline while a variable-latency load is outstanding.
`default_nettype none

module mem_wb_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             m_valid,
  input  logic             m_mem_read,
  input  logic             m_mem_write,
  input  logic             m_reg_write,
  input  logic [1:0]       m_result_src,
  input  logic [REGW-1:0]  m_rd,
  input  logic [WIDTH-1:0] m_alu_result,
  input  logic [WIDTH-1:0] m_write_data,
  input  logic [WIDTH-1:0] m_pc_plus4,
  input  logic [WIDTH-1:0] m_imm_ext,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             stall_m,
  output logic             w_valid,
  output logic             w_reg_write,
  output logic [REGW-1:0]  w_rd,
  output logic [1:0]       w_result_src,
  output logic [WIDTH-1:0] w_alu_result,
  output logic [WIDTH-1:0] w_read_data,
  output logic [WIDTH-1:0] w_pc_plus4,
  output logic [WIDTH-1:0] w_imm_ext
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic ld, st;
  logic capture, load_done;

  // A load that also claims to be a store is treated as a load.
  assign ld = m_valid & m_mem_read;
  assign st = m_valid & m_mem_write;

  assign dmem_addr  = m_alu_result;
  assign dmem_wdata = m_write_data;

  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    stall_m   = 1'b0;
    capture   = 1'b0;
    load_done = 1'b0;
    case (state)
      S_IDLE: begin
        dmem_req = ld | st;
        dmem_we  = st & ~ld;
        stall_m  = ld;
        capture  = m_valid & ~m_mem_read;
        if (ld) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        stall_m = ~dmem_rvalid;
        if (dmem_rvalid) begin
          capture   = 1'b1;
          load_done = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Non-capturing cycles insert a bubble; data registers keep their last values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_valid      <= 1'b0;
      w_reg_write  <= 1'b0;
      w_rd         <= '0;
      w_result_src <= '0;
      w_alu_result <= '0;
      w_read_data  <= '0;
      w_pc_plus4   <= '0;
      w_imm_ext    <= '0;
    end else if (capture) begin
      w_valid      <= 1'b1;
      w_reg_write  <= m_reg_write;
      w_rd         <= m_rd;
      w_result_src <= m_result_src;
      w_alu_result <= m_alu_result;
      w_pc_plus4   <= m_pc_plus4;
      w_imm_ext    <= m_imm_ext;
      if (load_done) w_read_data <= dmem_rdata;
    end else begin
      w_valid     <= 1'b0;
      w_reg_write <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors with hand-computed expectations for mem_wb_stage.
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_valid, m_mem_read, m_mem_write, m_reg_write;
  logic [1:0]  m_result_src;
  logic [4:0]  m_rd;
  logic [31:0] m_alu_result, m_write_data, m_pc_plus4, m_imm_ext;
  logic        dmem_req, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_m, w_valid, w_reg_write;
  logic [4:0]  w_rd;
  logic [1:0]  w_result_src;
  logic [31:0] w_alu_result, w_read_data, w_pc_plus4, w_imm_ext;

  int n_vec = 0;
  int n_err = 0;

  mem_wb_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_valid      (m_valid),
    .m_mem_read   (m_mem_read),
    .m_mem_write  (m_mem_write),
    .m_reg_write  (m_reg_write),
    .m_result_src (m_result_src),
    .m_rd         (m_rd),
    .m_alu_result (m_alu_result),
    .m_write_data (m_write_data),
    .m_pc_plus4   (m_pc_plus4),
    .m_imm_ext    (m_imm_ext),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .stall_m      (stall_m),
    .w_valid      (w_valid),
    .w_reg_write  (w_reg_write),
    .w_rd         (w_rd),
    .w_result_src (w_result_src),
    .w_alu_result (w_alu_result),
    .w_read_data  (w_read_data),
    .w_pc_plus4   (w_pc_plus4),
    .w_imm_ext    (w_imm_ext)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    {m_valid, m_mem_read, m_mem_write, m_reg_write} = '0;
    m_result_src = 2'b00; m_rd = '0;
    m_alu_result = '0; m_write_data = '0; m_pc_plus4 = '0; m_imm_ext = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;

    repeat (2) tick();
    check_eq("rst_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_m}, 32'd0);
    reset_n = 1'b1;

    // ALU instruction
    m_valid = 1; m_reg_write = 1; m_result_src = 2'b00; m_rd = 5;
    m_alu_result = 32'h10; m_pc_plus4 = 32'h8; m_imm_ext = 32'h77;
    #1;
    check_eq("alu_stall", {31'd0, stall_m}, 32'd0);
    check_eq("alu_req", {31'd0, dmem_req}, 32'd0);
    tick();
    check_eq("alu_w_valid", {31'd0, w_valid}, 32'd1);
    check_eq("alu_w_regwr", {31'd0, w_reg_write}, 32'd1);
    check_eq("alu_w_alu", w_alu_result, 32'h10);
    check_eq("alu_w_rd", {27'd0, w_rd}, 32'd5);
    check_eq("alu_w_src", {30'd0, w_result_src}, 32'd0);
    check_eq("alu_w_imm", w_imm_ext, 32'h77);

    // Store
    m_mem_write = 1; m_reg_write = 0; m_rd = 0;
    m_alu_result = 32'h100; m_write_data = 32'hCAFEF00D;
    #1;
    check_eq("st_req", {31'd0, dmem_req}, 32'd1);
    check_eq("st_we", {31'd0, dmem_we}, 32'd1);
    check_eq("st_addr", dmem_addr, 32'h100);
    check_eq("st_wdata", dmem_wdata, 32'hCAFEF00D);
    check_eq("st_stall", {31'd0, stall_m}, 32'd0);
    tick();
    check_eq("st_w_valid", {31'd0, w_valid}, 32'd1);
    check_eq("st_w_regwr", {31'd0, w_reg_write}, 32'd0);
    check_eq("st_w_alu", w_alu_result, 32'h100);

    // Load answered 3 cycles after the request
    m_mem_write = 0; m_mem_read = 1; m_reg_write = 1; m_result_src = 2'b01;
    m_rd = 7; m_alu_result = 32'h200;
    #1;
    check_eq("ld3_req_c0", {31'd0, dmem_req}, 32'd1);
    check_eq("ld3_we_c0", {31'd0, dmem_we}, 32'd0);
    check_eq("ld3_stall_c0", {31'd0, stall_m}, 32'd1);
    tick();
    check_eq("ld3_req_c1", {31'd0, dmem_req}, 32'd0);
    check_eq("ld3_stall_c1", {31'd0, stall_m}, 32'd1);
    check_eq("ld3_w_valid_c1", {31'd0, w_valid}, 32'd0);
    tick();
    check_eq("ld3_req_c2", {31'd0, dmem_req}, 32'd0);
    check_eq("ld3_stall_c2", {31'd0, stall_m}, 32'd1);
    check_eq("ld3_w_valid_c2", {31'd0, w_valid}, 32'd0);
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    #1;
    check_eq("ld3_stall_c3", {31'd0, stall_m}, 32'd0);
    check_eq("ld3_req_c3", {31'd0, dmem_req}, 32'd0);
    check_eq("ld3_w_valid_c3", {31'd0, w_valid}, 32'd0);
    tick();
    check_eq("ld3_w_valid", {31'd0, w_valid}, 32'd1);
    check_eq("ld3_w_rdata", w_read_data, 32'h12345678);
    check_eq("ld3_w_src", {30'd0, w_result_src}, 32'd1);
    check_eq("ld3_w_rd", {27'd0, w_rd}, 32'd7);

    // Load answered after 1 cycle, then a second load immediately
    dmem_rvalid = 0; m_rd = 8; m_alu_result = 32'h300;
    #1;
    check_eq("ldA_req", {31'd0, dmem_req}, 32'd1);
    check_eq("ldA_stall_c0", {31'd0, stall_m}, 32'd1);
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'hAAAA0001;
    #1;
    check_eq("ldA_stall_c1", {31'd0, stall_m}, 32'd0);
    check_eq("ldA_req_c1", {31'd0, dmem_req}, 32'd0);
    tick();
    check_eq("ldA_w_valid", {31'd0, w_valid}, 32'd1);
    check_eq("ldA_w_rdata", w_read_data, 32'hAAAA0001);
    check_eq("ldA_w_rd", {27'd0, w_rd}, 32'd8);
    dmem_rvalid = 0; m_rd = 9; m_alu_result = 32'h304;
    #1;
    check_eq("ldB_req", {31'd0, dmem_req}, 32'd1);
    check_eq("ldB_addr", dmem_addr, 32'h304);
    check_eq("ldB_stall", {31'd0, stall_m}, 32'd1);
    tick();
    check_eq("ldB_bubble", {31'd0, w_valid}, 32'd0);
    dmem_rvalid = 1; dmem_rdata = 32'hBBBB0002;
    tick();
    check_eq("ldB_w_valid", {31'd0, w_valid}, 32'd1);
    check_eq("ldB_w_rdata", w_read_data, 32'hBBBB0002);
    check_eq("ldB_w_rd", {27'd0, w_rd}, 32'd9);

    // Two bubbles with a stray response, then JAL
    dmem_rvalid = 1; dmem_rdata = 32'h0BADF00D;
    m_valid = 0; m_mem_read = 0; m_reg_write = 1;
    tick();
    check_eq("bub1_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("bub1_w_regwr", {31'd0, w_reg_write}, 32'd0);
    dmem_rvalid = 0;
    tick();
    check_eq("bub2_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("bub2_w_regwr", {31'd0, w_reg_write}, 32'd0);
    check_eq("bub2_w_rdata_hold", w_read_data, 32'hBBBB0002);
    check_eq("bub2_w_rd_hold", {27'd0, w_rd}, 32'd9);
    m_valid = 1; m_result_src = 2'b10; m_rd = 1; m_pc_plus4 = 32'h44;
    tick();
    check_eq("jal_w_valid", {31'd0, w_valid}, 32'd1);
    check_eq("jal_w_pc4", w_pc_plus4, 32'h44);
    check_eq("jal_w_src", {30'd0, w_result_src}, 32'd2);
    check_eq("jal_w_rdata_hold", w_read_data, 32'hBBBB0002);
    check_eq("jal_w_alu", w_alu_result, 32'h304);
    check_eq("jal_w_imm", w_imm_ext, 32'h77);

    // Reset asserted while a load is outstanding
    m_mem_read = 1; m_result_src = 2'b01; m_rd = 3; m_alu_result = 32'h400;
    tick();
    check_eq("rw_stall_wait", {31'd0, stall_m}, 32'd1);
    reset_n = 0; m_valid = 0; m_mem_read = 0;
    #1;
    check_eq("rw_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("rw_w_regwr", {31'd0, w_reg_write}, 32'd0);
    check_eq("rw_w_rd", {27'd0, w_rd}, 32'd0);
    check_eq("rw_w_src", {30'd0, w_result_src}, 32'd0);
    check_eq("rw_w_alu", w_alu_result, 32'd0);
    check_eq("rw_w_rdata", w_read_data, 32'd0);
    check_eq("rw_w_pc4", w_pc_plus4, 32'd0);
    check_eq("rw_w_imm", w_imm_ext, 32'd0);
    check_eq("rw_stall", {31'd0, stall_m}, 32'd0);
    check_eq("rw_req", {31'd0, dmem_req}, 32'd0);
    tick();
    reset_n = 1; dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    check_eq("rw_post_w_valid", {31'd0, w_valid}, 32'd0);
    check_eq("rw_post_w_rdata", w_read_data, 32'd0);
    check_eq("rw_post_stall", {31'd0, stall_m}, 32'd0);
    dmem_rvalid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
